conv_layer_ctrl: RTL
====================

CONV_LAYER_CTRL -- requirements
Module: conv_layer_ctrl

Interface
REQ-001 Parameter FRAME_H_MAX, 224, maximum input frame height in pixels.
REQ-002 Parameter FRAME_W_MAX, 224, maximum input frame width in pixels.
REQ-003 Parameter STRIDE_MAX, 4, maximum stride value.
REQ-004 Parameter WIN_SIZE, 3, convolution window side.
REQ-005 Parameter DIN_WIDTH, 8, bits per channel sample.
REQ-006 Parameter CHANNELS_IN, 4, input channels per pixel.
REQ-007 Parameter ADDR_WIDTH, 16, source memory address width.
REQ-008 Parameter TIMEOUT, 1024, maximum idle cycles allowed in DRAIN.
REQ-009 clk  in  1  single clock; all logic rising-edge.
REQ-010 reset_n  in  1  asynchronous, active-low reset.
REQ-011 start  in  1  one-cycle pulse that launches a layer pass.
REQ-012 cfg_frame_h / cfg_frame_w  in  clog2(FRAME_H_MAX)+1 / clog2(FRAME_W_MAX)+1  frame size.
REQ-013 cfg_stride / cfg_indent  in  clog2(STRIDE_MAX)+1 / clog2(WIN_SIZE/2)+1  stride and padding.
REQ-014 cfg_base  in  ADDR_WIDTH  source address of pixel (0,0).
REQ-015 cfg_out_pix  in  32  expected number of dout_vld pulses for the pass.
REQ-016 src_en  in  1  throttle; read issued only when high.
REQ-017 rd_en / rd_addr  out  1 / ADDR_WIDTH  source read request, data returned one cycle later.
REQ-018 rd_data  in  CHANNELS_IN*DIN_WIDTH  source read data.
REQ-019 frame_h, frame_w, stride, indent  out  as REQ-012/013  latched configuration driven to the conv datapath.
REQ-020 fin_start, din_vld, din  out  1, 1, CHANNELS_IN*DIN_WIDTH  pixel stream to the conv datapath.
REQ-021 fout_start, dout_vld  in  1, 1  conv datapath output strobes.
REQ-022 busy, done, err_timeout  out  1 each  status; done and err_timeout are one-cycle pulses.

Function
REQ-023 States IDLE, STREAM, DRAIN; IDLE->STREAM on start, STREAM->DRAIN after last read issued, DRAIN->IDLE when out count equals cfg_out_pix or on timeout.
REQ-024 In IDLE with start=1: cfg_* latched into frame_h..indent outputs and internal base/out_pix registers; start ignored outside IDLE.
REQ-025 In STREAM: rd_en = src_en; row/col counters advance only on rd_en; rd_addr = base + row*frame_w + col, row-major, col wraps at frame_w-1 to 0 with row+1.
REQ-026 Last read is row=frame_h-1, col=frame_w-1; STREAM->DRAIN in the cycle after it.
REQ-027 din_vld = rd_en delayed one cycle; din = rd_data (combinational pass-through, aligned with din_vld).
REQ-028 fin_start = 1 for exactly the cycle of the first din_vld of the pass.
REQ-029 Output counter (32 bits) cleared on start, increments on dout_vld in STREAM and DRAIN; fout_start ignored except it does not clear the counter.
REQ-030 Completion when counter reaches cfg_out_pix (including the dout_vld that reaches it in STREAM): done pulses next cycle, state IDLE.
REQ-031 DRAIN idle counter resets on each dout_vld; reaching TIMEOUT consecutive cycles without dout_vld pulses err_timeout (not done) and returns to IDLE.
REQ-032 busy = 1 in STREAM and DRAIN, 0 in IDLE.
REQ-033 cfg_out_pix = 0: pass streams all pixels, done pulses on the first DRAIN cycle.
REQ-034 cfg_frame_h or cfg_frame_w = 0 at start: no reads, done pulses next cycle, no fin_start.
REQ-035 Address arithmetic wraps modulo 2^ADDR_WIDTH.

Reset
REQ-036 reset_n low, at any time including mid-pass, forces IDLE; rd_en, din_vld, fin_start, busy, done, err_timeout = 0; counters and latched cfg = 0; rd_addr = 0.
REQ-037 Reset removal requires start to begin a new pass; no pending read completes.

Verification
REQ-038 4x4 frame, base=0x100, src_en=1, out_pix=4: rd_addr 0x100..0x10F consecutive, fin_start with first din_vld, 16 din_vld, done one cycle after 4th dout_vld.
REQ-039 3x5 frame, src_en toggled 1/0 each cycle: 15 reads, addresses monotonic, din_vld only in cycles following rd_en, done after expected outputs.
REQ-040 out_pix=9, only 5 dout_vld returned: err_timeout pulses TIMEOUT cycles after the 5th, done never asserted, busy drops.
REQ-041 reset_n low during STREAM at pixel 7: all outputs 0 next edge-independent; new start restarts at base with fin_start.
REQ-042 start asserted while busy: cfg outputs unchanged, pass completes normally.
REQ-043 frame_w=0 at start: zero reads, no fin_start, done one cycle later.

Source files
------------

// File: rtl/conv_layer_ctrl.sv
// Conv layer pass controller: streams a frame from source memory
// into the conv datapath and tracks output pixels to completion.
module conv_layer_ctrl #(
  parameter int FRAME_H_MAX = 224,
  parameter int FRAME_W_MAX = 224,
  parameter int STRIDE_MAX  = 4,
  parameter int WIN_SIZE    = 3,
  parameter int DIN_WIDTH   = 8,
  parameter int CHANNELS_IN = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int TIMEOUT     = 1024,
  localparam int HW = $clog2(FRAME_H_MAX) + 1,
  localparam int WW = $clog2(FRAME_W_MAX) + 1,
  localparam int SW = $clog2(STRIDE_MAX) + 1,
  localparam int IW = $clog2(WIN_SIZE / 2) + 1,
  localparam int DW = CHANNELS_IN * DIN_WIDTH,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [HW-1:0]         cfg_frame_h,
  input  logic [WW-1:0]         cfg_frame_w,
  input  logic [SW-1:0]         cfg_stride,
  input  logic [IW-1:0]         cfg_indent,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [31:0]           cfg_out_pix,
  input  logic                  src_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DW-1:0]         rd_data,
  output logic [HW-1:0]         frame_h,
  output logic [WW-1:0]         frame_w,
  output logic [SW-1:0]         stride,
  output logic [IW-1:0]         indent,
  output logic                  fin_start,
  output logic                  din_vld,
  output logic [DW-1:0]         din,
  input  logic                  fout_start,
  input  logic                  dout_vld,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t                state;
  logic [HW-1:0]         row;
  logic [WW-1:0]         col;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           out_pix;
  logic [31:0]           out_cnt;
  logic [31:0]           cnt_nxt;
  logic [TW-1:0]         idle_cnt;
  logic                  first;
  logic                  col_end;
  logic                  last_rd;
  logic                  hit;
  logic                  zero_dim;
  logic                  unused_ok;

  assign unused_ok = fout_start;

  assign rd_en     = (state == STREAM) && src_en;
  assign rd_addr   = addr;
  assign din       = rd_data;
  assign fin_start = din_vld && first;
  assign busy      = (state != IDLE);

  assign cnt_nxt  = out_cnt + {31'b0, dout_vld};
  assign col_end  = (col == frame_w - WW'(1));
  assign last_rd  = rd_en && col_end &&
                    (row == frame_h - HW'(1));
  assign zero_dim = (cfg_frame_h == '0) ||
                    (cfg_frame_w == '0);

  // In STREAM only a real output can complete the pass, so an
  // out_pix of 0 still streams the whole frame.
  assign hit = (cnt_nxt == out_pix) &&
               (dout_vld || state == DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      addr        <= '0;
      out_pix     <= '0;
      out_cnt     <= '0;
      idle_cnt    <= '0;
      first       <= 1'b0;
      frame_h     <= '0;
      frame_w     <= '0;
      stride      <= '0;
      indent      <= '0;
      din_vld     <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      din_vld     <= rd_en;
      if (din_vld) first <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            frame_h  <= cfg_frame_h;
            frame_w  <= cfg_frame_w;
            stride   <= cfg_stride;
            indent   <= cfg_indent;
            addr     <= cfg_base;
            out_pix  <= cfg_out_pix;
            out_cnt  <= '0;
            idle_cnt <= '0;
            row      <= '0;
            col      <= '0;
            if (zero_dim) begin
              done  <= 1'b1;
              first <= 1'b0;
            end else begin
              state <= STREAM;
              first <= 1'b1;
            end
          end
        end
        STREAM: begin
          out_cnt <= cnt_nxt;
          if (rd_en) begin
            addr <= addr + ADDR_WIDTH'(1);
            if (col_end) begin
              col <= '0;
              row <= row + HW'(1);
            end else begin
              col <= col + WW'(1);
            end
          end
          if (hit) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (last_rd) begin
            state    <= DRAIN;
            idle_cnt <= '0;
          end
        end
        DRAIN: begin
          out_cnt <= cnt_nxt;
          if (hit) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (dout_vld) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
